// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer and architectural HI/LO holder for the EX stage.
// Optional accumulate ops (madd/maddu, op 7/8) are built only when MDU_MADD_EN is defined.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned PROD_W     = 2 * DATA_W;
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   sh_hi_q, sh_hi_d;
    logic [DATA_W-1:0]   sh_lo_q, sh_lo_d;

    logic                is_mul;
    logic                is_div;
    logic                is_signed;
    logic                is_mthi;
    logic                is_mtlo;
`ifdef MDU_MADD_EN
    logic                is_madd;
`endif

    logic [PROD_W-1:0]   mul_a;
    logic [PROD_W-1:0]   mul_b;
    logic [PROD_W-1:0]   product;
    logic [PROD_W-1:0]   mul_res;

    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W-1:0]   den;
    logic [DATA_W-1:0]   q_mag;
    logic [DATA_W-1:0]   r_mag;
    logic [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]   rem;
    logic                div_by_zero;

    // Opcode decode; ops outside the supported set decode to nothing.
    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
`ifdef MDU_MADD_EN
        is_madd   = 1'b0;
`endif
        case (op)
            OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
            OP_MULTU: begin is_mul = 1'b1; end
            OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
            OP_DIVU:  begin is_div = 1'b1; end
            OP_MTHI:  begin is_mthi = 1'b1; end
            OP_MTLO:  begin is_mtlo = 1'b1; end
`ifdef MDU_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; is_madd = 1'b1; is_signed = 1'b1; end
            OP_MADDU: begin is_mul = 1'b1; is_madd = 1'b1; end
`endif
            default:  ;
        endcase
    end

    // One 64-bit multiplier serves both signednesses: the low 64 bits of the
    // product of the sign- or zero-extended operands are the exact result.
    always_comb begin
        mul_a   = is_signed ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
        mul_b   = is_signed ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
        product = mul_a * mul_b;
`ifdef MDU_MADD_EN
        mul_res = is_madd ? ({hi_q, lo_q} + product) : product;
`else
        mul_res = product;
`endif
    end

    // Sign-magnitude divide: truncation toward zero falls out naturally, and
    // 0x80000000 / -1 yields quotient 0x80000000, remainder 0 without a special case.
    always_comb begin
        a_neg       = is_signed & a[DATA_W-1];
        b_neg       = is_signed & b[DATA_W-1];
        a_mag       = a_neg ? DATA_W'(~a + 32'd1) : a;
        b_mag       = b_neg ? DATA_W'(~b + 32'd1) : b;
        div_by_zero = (b == '0);
        den         = div_by_zero ? DATA_W'(1) : b_mag;
        q_mag       = a_mag / den;
        r_mag       = a_mag % den;
        quot        = (a_neg ^ b_neg) ? DATA_W'(~q_mag + 32'd1) : q_mag;
        rem         = a_neg ? DATA_W'(~r_mag + 32'd1) : r_mag;
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        {sh_hi_d, sh_lo_d} = mul_res;
                        cnt_d   = CNT_W'(MULT_CYCLES);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else if (is_div) begin
                        // Divide by zero still occupies the unit but commits the old HI/LO.
                        if (div_by_zero) begin
                            sh_hi_d = hi_q;
                            sh_lo_d = lo_q;
                        end else begin
                            sh_hi_d = rem;
                            sh_lo_d = quot;
                        end
                        cnt_d   = CNT_W'(DIV_CYCLES);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else if (is_mthi) begin
                        hi_d = a;
                    end else if (is_mtlo) begin
                        lo_d = a;
                    end
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = sh_hi_q;
                    lo_d    = sh_lo_q;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO and busy length queued at issue, checked at completion.
module tb_mdu_ctrl;

    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;
    localparam int unsigned WAIT_LIMIT  = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cycles;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_ctrl #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference HI/LO after an op, from plain SV integer arithmetic.
    function automatic logic [63:0] ref_hilo(input logic [3:0] f_op, input logic [31:0] x,
                                             input logic [31:0] y, input logic [31:0] h,
                                             input logic [31:0] l);
        longint      sx;
        longint      sy;
        int          ix;
        int          iy;
        logic [63:0] ux;
        logic [63:0] uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        ix = x;
        iy = y;
        case (f_op)
            4'd1: return 64'(sx * sy);
            4'd2: return ux * uy;
            4'd3: begin
                if (y == 32'd0) return {h, l};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(ix % iy), 32'(ix / iy)};
            end
            4'd4: begin
                if (y == 32'd0) return {h, l};
                return {x % y, x / y};
            end
            4'd5: return {x, l};
            4'd6: return {h, x};
`ifdef MDU_MADD_EN
            4'd7: return {h, l} + 64'(sx * sy);
            4'd8: return {h, l} + ux * uy;
`endif
            default: return {h, l};
        endcase
    endfunction

    function automatic int unsigned ref_cycles(input logic [3:0] f_op);
        case (f_op)
            4'd1, 4'd2: return MULT_CYCLES;
            4'd3, 4'd4: return DIV_CYCLES;
`ifdef MDU_MADD_EN
            4'd7, 4'd8: return MULT_CYCLES;
`endif
            default: return 0;
        endcase
    endfunction

    // Issue one op, watch busy (HI/LO must hold), then compare against the scoreboard.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit poke_mtlo);
        exp_t        e;
        logic [63:0] r;
        int unsigned n;
        r        = ref_hilo(o, x, y, m_hi, m_lo);
        e.tag    = tag;
        e.hi     = r[63:32];
        e.lo     = r[31:0];
        e.cycles = ref_cycles(o);
        sb_q.push_back(e);

        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        n = 0;
        while (busy === 1'b1 && n < WAIT_LIMIT) begin
            check({tag, "_hold_hi"}, 64'(hi), 64'(m_hi));
            check({tag, "_hold_lo"}, 64'(lo), 64'(m_lo));
            if (poke_mtlo && n == 1) begin
                start = 1'b1; op = 4'd6; a = 32'h0000_1234;
            end else begin
                start = 1'b0; op = 4'd0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0; op = 4'd0;

        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, "_busy_cycles"}, 64'(n), 64'(e.cycles));
            check({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
            check({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        // Asynchronous reset in the second busy cycle discards the pending mult.
        run_op("mthi_pre", 4'd5, 32'hAAAA_5555, 32'd0, 1'b0);
        run_op("mtlo_pre", 4'd6, 32'h5555_AAAA, 32'd0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        check("rstrun_busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rstrun_busy", 64'(busy), 64'd0);
        check("rstrun_hi", 64'(hi), 64'd0);
        check("rstrun_lo", 64'(lo), 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("rstrun_after_busy", 64'(busy), 64'd0);
        check("rstrun_after_hi", 64'(hi), 64'd0);
        check("rstrun_after_lo", 64'(lo), 64'd0);

        run_op("mult", 4'd1, 32'd3, 32'hFFFF_FFFE, 1'b0);
        check("mult_hi_const", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo_const", 64'(lo), 64'hFFFF_FFFA);

        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("multu_hi_const", 64'(hi), 64'h0000_0001);
        check("multu_lo_const", 64'(lo), 64'hFFFF_FFFE);

        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_hi_const", 64'(hi), 64'hFFFF_FFFF);
        check("div_lo_const", 64'(lo), 64'hFFFF_FFFD);

        run_op("mthi", 4'd5, 32'h11, 32'd0, 1'b0);
        run_op("mtlo", 4'd6, 32'h22, 32'd0, 1'b0);
        run_op("divu_by0", 4'd4, 32'd7, 32'd0, 1'b0);
        check("divu_by0_hi_const", 64'(hi), 64'h11);
        check("divu_by0_lo_const", 64'(lo), 64'h22);
        run_op("div_by0", 4'd3, 32'hFFFF_FFF0, 32'd0, 1'b0);

        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_hi_const", 64'(hi), 64'h0);
        check("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
        run_op("div_negb", 4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("divu_big", 4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);

        // mtlo issued during busy must be dropped, then take effect when reissued.
        run_op("mult_poke", 4'd2, 32'd10, 32'd20, 1'b1);
        run_op("mtlo_after", 4'd6, 32'h0000_1234, 32'd0, 1'b0);
        check("mtlo_after_const", 64'(lo), 64'h1234);

        for (int i = 0; i < 16; i++) begin
            if (i == 0 || i >= 9) run_op("noop", 4'(i), 32'hDEAD_BEEF, 32'd3, 1'b0);
        end

        run_op("madd_pre_hi", 4'd5, 32'd0, 32'd0, 1'b0);
        run_op("madd_pre_lo", 4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op("madd", 4'd7, 32'd1, 32'd1, 1'b0);
        run_op("madd_neg", 4'd7, 32'hFFFF_FFFF, 32'd5, 1'b0);
        run_op("maddu", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        for (int i = 0; i < 24; i++) begin
            r_op = 4'($urandom_range(1, 8));
            r_a  = $urandom;
            r_b  = (i % 6 == 5) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom);
            run_op("rand", r_op, r_a, r_b, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencing controller and result holder for the pipeline's multiply/divide resource (HI/LO).
- Sits in the EX stage. Accepts one md operation per start pulse and models the multi-cycle latency with a down-counter.
- Drives `busy` to the stall logic; the stall logic blocks every md instruction in ID while `busy | start`.
- Owns the architectural HI/LO registers read by mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu/madd/maddu (must be >= 1)
- DIV_CYCLES, 10, busy duration in cycles for div/divu (must be >= 1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  EX-stage strobe, one cycle per md instruction
- op  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu
- a  input  32  forwarded rs value
- b  input  32  forwarded rt value
- busy  output  1  long operation in flight
- hi  output  32  architectural HI
- lo  output  32  architectural LO

Behaviour:
- Reset (async, any time, including mid-operation): busy=0, hi=0, lo=0, cnt=0, FSM=IDLE. Pending result is discarded.
- FSM states: IDLE, RUN.
- IDLE, start=1, op in {1,2,3,4,7,8}: at the edge, compute the result into shadow registers sh_hi/sh_lo, load cnt with MULT_CYCLES or DIV_CYCLES, busy<=1, go to RUN.
- IDLE, start=1, op=5 (mthi) or op=6 (mtlo): at the edge, hi<=a or lo<=a. No busy, stay in IDLE.
- start=1 with op=0 or op in 9..15: no effect.
- RUN: cnt decrements each edge. At the edge where cnt==1: hi<=sh_hi, lo<=sh_lo, busy<=0, go to IDLE.
- busy is therefore high for exactly N cycles. New HI/LO values are visible in the first cycle busy is low.
- start while busy=1: ignored entirely, including mthi/mtlo. The stall logic guarantees this never happens; a bench may still check that it is ignored.
- mult: signed 32x32 -> 64, {hi,lo} = a*b.
- multu: the same, unsigned.
- div: signed. lo = quotient truncated toward zero; hi = remainder, which takes the sign of a.
- divu: the same, unsigned.
- 0x80000000 / -1 (signed): lo=0x80000000, hi=0.
- Divide by zero (b==0, div or divu): the operation still runs its full DIV_CYCLES with busy=1, then HI/LO are left unchanged.
- madd: {hi,lo} <= {hi,lo} + signed a*b, modulo 2^64.
- maddu: the same, unsigned.
- madd/maddu sample HI/LO at start, which is legal because HI/LO cannot change while RUN.
- hi and lo are direct register outputs: no combinational path from any input.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: op 7 and op 8 behave as madd/maddu above.
- Undefined: op 7 and op 8 are treated as no-ops. No busy, no HI/LO change, and the 64-bit accumulate adder is not synthesised.

Test Plan:
- Async reset mid-RUN: start mult, assert reset in cycle 2 between edges -> busy=0, hi=lo=0 immediately; no later update after reset is released.
- mult a=3, b=0xFFFFFFFE -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. hi/lo keep their old values while busy=1.
- multu a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=7, b=0 with hi=0x11, lo=0x22 preloaded via mthi/mtlo -> busy for 10 cycles; then hi=0x11, lo=0x22.
- mtlo a=0x1234 issued while busy=1 -> ignored, lo unchanged. Reissued after busy falls -> lo=0x1234 next cycle, busy stays 0.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, madd a=1, b=1 -> after 5 cycles hi=1, lo=0. Without the macro, the same stimulus -> no busy, hi/lo unchanged.
